ro_cache_mem_rd_arb: RTL and testbench
======================================

Name: ro_cache_mem_rd_arb

Overview:
- Shares the single downstream burst-read memory channel (req/gnt, len/addr, valid/ready data, done) among CACHE_NUM read-only cache controllers.
- Round-robin arbitration; the channel stays locked to one owner from grant until rd_done.
- Sits between the per-cache refill ports and the memory-side read port.

Parameters:
- CACHE_NUM, 4, number of requesting cache controllers (>=2).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data beat width.
- ID_WIDTH, $clog2(CACHE_NUM), owner index width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- up_rd_req  in  CACHE_NUM  per-cache burst request; held until its up_rd_gnt.
- up_rd_gnt  out  CACHE_NUM  one-hot grant pulse.
- up_rd_len  in  16*CACHE_NUM  packed beat counts; slice i belongs to cache i.
- up_rd_addr  in  ADDR_WIDTH*CACHE_NUM  packed start addresses.
- up_rd_data  out  DATA_WIDTH  read data, broadcast to all caches.
- up_rd_valid  out  CACHE_NUM  data valid, owner bit only.
- up_rd_ready  in  CACHE_NUM  data ready.
- up_rd_done  out  CACHE_NUM  burst-complete pulse, owner bit only.
- rd_req  out  1  memory burst request.
- rd_gnt  in  1  memory grant pulse.
- rd_len  out  16  burst beat count.
- rd_addr  out  ADDR_WIDTH  burst start address.
- rd_data  in  DATA_WIDTH  memory data.
- rd_valid  in  1  memory data valid.
- rd_ready  out  1  memory data ready.
- rd_done  in  1  memory burst-complete pulse.
- busy  out  1  channel owned (state != IDLE).
- owner  out  ID_WIDTH  current/last owner index.

Behaviour:
- Reset values: rd_req, rd_len, rd_addr, rd_ready, up_rd_gnt, up_rd_valid, up_rd_done, busy, owner all 0; rr pointer 0; state IDLE.
- FSM states IDLE, REQ, XFER.
- IDLE:
  - If any up_rd_req is set, select the first set bit searching from the rr pointer upward, with wrap.
  - Register owner, rd_len and rd_addr from that slice.
  - Move to REQ next cycle. rd_req goes high 1 cycle after the request is seen.
- REQ:
  - rd_req=1; rd_len and rd_addr stay stable.
  - On rd_gnt=1: up_rd_gnt[owner]=1 combinationally in the same cycle; move to XFER next cycle.
  - rd_req drops in the cycle after rd_gnt.
- XFER:
  - up_rd_data=rd_data at all times.
  - up_rd_valid[owner]=rd_valid; rd_ready=up_rd_ready[owner]; all other bits 0. No buffering, zero added latency.
  - On rd_done=1: up_rd_done[owner]=1 in the same cycle; rr pointer becomes owner+1 mod CACHE_NUM; IDLE next cycle.
- rd_done may coincide with the last accepted beat. Data beats arriving in REQ are not forwarded (rd_ready=0).
- Requests arriving during REQ/XFER wait. The first re-arbitration happens in the IDLE cycle after done, so there is exactly 1 bubble cycle between bursts.
- Requester dropping up_rd_req before its grant is a protocol violation; the latched request still completes.
- rr wrap: owner CACHE_NUM-1 sets the pointer to 0.
- rst during REQ/XFER aborts immediately to the reset values. Memory-side cleanup is the system's responsibility.
- Starvation bound: a held request is granted within CACHE_NUM-1 other bursts.

Optional Feature:
- Macro RO_CACHE_RD_ARB_BEAT_CHECK_EN.
- When defined:
  - A 16-bit beat counter clears on entry to XFER and increments on each rd_valid&&rd_ready.
  - Output err_beat (1 bit, sticky, cleared only by rst) sets when rd_done arrives with count != rd_len (counting the same-cycle beat), or when a beat is accepted after count reached rd_len.
- When undefined: no counter, no err_beat port.

Decomposition:
- Package ro_cache_rd_arb_pkg holds:
  - the state enum typedef (IDLE/REQ/XFER);
  - localparam LEN_WIDTH=16;
  - a function that rotate-searches a one-hot-first grant from a pointer.
- One sub-module, ro_cache_rr_pick: combinational round-robin picker (req vector + pointer in, index + found out).

Test Plan:
- Single requester: cache 2 requests len=4 at addr 0x100; mem gnt after 3 cycles, then 4 beats and done. Check: rd_req 1 cycle after request; up_rd_gnt=4'b0100 in the gnt cycle; 4 beats only on up_rd_valid[2]; up_rd_done[2] pulse; busy low next cycle.
- Simultaneous 4'b1111 with pointer 0, each burst len=2. Check: grant order 0,1,2,3; exactly 1 idle cycle between bursts; pointer returns to 0.
- Backpressure: owner 1 toggles up_rd_ready every other cycle over 8 beats. Check: rd_ready mirrors it exactly; no beat lost or duplicated; other valid bits stay 0.
- Fairness: cache 0 re-requests immediately after each done while cache 3 holds its request. Check: cache 3 is granted no later than the second burst.
- Reset mid-XFER after 2 of 4 beats. Check: next cycle all outputs 0, state IDLE; a new request from cache 1 is granted starting from pointer 0.
- With RO_CACHE_RD_ARB_BEAT_CHECK_EN:
  - rd_done after 3 beats with len=4 -> err_beat=1 and stays set.
  - A correct len=4 burst leaves err_beat=0.

Source files
------------

// File: rtl/ro_cache_mem_rd_arb_pkg.sv
// Shared types and helpers for the read-only cache memory read arbiter.
package ro_cache_rd_arb_pkg;

  localparam int LEN_WIDTH = 16;
  localparam int MAX_REQ   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } arb_state_e;

  // First set request at or after ptr, wrapping at n; returns a one-hot vector.
  function automatic logic [MAX_REQ-1:0] rr_first_onehot(
    input logic [MAX_REQ-1:0] req,
    input int unsigned        ptr,
    input int unsigned        n
  );
    logic [MAX_REQ-1:0] gnt;
    logic               found;
    int unsigned        sum;
    logic [4:0]         sel;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (i < n) begin
        sum = ptr + i;
        if (sum >= n) sum = sum - n;
        sel = sum[4:0];
        if (!found && req[sel]) begin
          gnt[sel] = 1'b1;
          found    = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/ro_cache_mem_rd_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, with wrap.
module ro_cache_rr_pick
  import ro_cache_rd_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] idx,
  output logic           found
);

  logic [MAX_REQ-1:0] req_ext;
  logic [MAX_REQ-1:0] onehot;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
  end

  assign onehot = rr_first_onehot(req_ext, 32'(ptr), N);
  assign found  = |onehot;

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) idx = IDW'(i);
    end
  end

endmodule

// File: rtl/ro_cache_mem_rd_arb.sv
// Round-robin arbiter sharing one burst-read memory channel among CACHE_NUM caches.
// Optional beat-count checking with err_beat output: define RO_CACHE_RD_ARB_BEAT_CHECK_EN.
module ro_cache_mem_rd_arb
  import ro_cache_rd_arb_pkg::*;
#(
  parameter int CACHE_NUM  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = $clog2(CACHE_NUM)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CACHE_NUM-1:0]            up_rd_req,
  output logic [CACHE_NUM-1:0]            up_rd_gnt,
  input  logic [LEN_WIDTH*CACHE_NUM-1:0]  up_rd_len,
  input  logic [ADDR_WIDTH*CACHE_NUM-1:0] up_rd_addr,
  output logic [DATA_WIDTH-1:0]           up_rd_data,
  output logic [CACHE_NUM-1:0]            up_rd_valid,
  input  logic [CACHE_NUM-1:0]            up_rd_ready,
  output logic [CACHE_NUM-1:0]            up_rd_done,
  output logic                            rd_req,
  input  logic                            rd_gnt,
  output logic [LEN_WIDTH-1:0]            rd_len,
  output logic [ADDR_WIDTH-1:0]           rd_addr,
  input  logic [DATA_WIDTH-1:0]           rd_data,
  input  logic                            rd_valid,
  output logic                            rd_ready,
  input  logic                            rd_done,
  output logic                            busy,
  output logic [ID_WIDTH-1:0]             owner
`ifdef RO_CACHE_RD_ARB_BEAT_CHECK_EN
  ,
  output logic                            err_beat
`endif
);

  arb_state_e              state_reg;
  logic [ID_WIDTH-1:0]     owner_reg;
  logic [ID_WIDTH-1:0]     rr_ptr_reg;
  logic [LEN_WIDTH-1:0]    len_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [ID_WIDTH-1:0]     pick_idx;
  logic                    pick_found;
  logic [ID_WIDTH-1:0]     ptr_after_done;
  logic                    in_req;
  logic                    in_xfer;

  ro_cache_rr_pick #(
    .N   (CACHE_NUM),
    .IDW (ID_WIDTH)
  ) u_pick (
    .req   (up_rd_req),
    .ptr   (rr_ptr_reg),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign ptr_after_done = (owner_reg == ID_WIDTH'(CACHE_NUM - 1)) ? '0 : owner_reg + 1'b1;

  // Owner, length and address are latched once at arbitration and held until done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      owner_reg  <= '0;
      rr_ptr_reg <= '0;
      len_reg    <= '0;
      addr_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            owner_reg <= pick_idx;
            len_reg   <= up_rd_len[pick_idx*LEN_WIDTH +: LEN_WIDTH];
            addr_reg  <= up_rd_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
            state_reg <= REQ;
          end
        end
        REQ: begin
          if (rd_gnt) state_reg <= XFER;
        end
        XFER: begin
          if (rd_done) begin
            rr_ptr_reg <= ptr_after_done;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_req     = (state_reg == REQ);
  assign in_xfer    = (state_reg == XFER);
  assign rd_req     = in_req;
  assign rd_len     = len_reg;
  assign rd_addr    = addr_reg;
  assign busy       = (state_reg != IDLE);
  assign owner      = owner_reg;
  assign up_rd_data = rd_data;
  assign rd_ready   = in_xfer & up_rd_ready[owner_reg];

  for (genvar gi = 0; gi < CACHE_NUM; gi++) begin : g_port
    logic is_owner;
    assign is_owner        = (owner_reg == ID_WIDTH'(gi));
    assign up_rd_gnt[gi]   = in_req  & rd_gnt   & is_owner;
    assign up_rd_valid[gi] = in_xfer & rd_valid & is_owner;
    assign up_rd_done[gi]  = in_xfer & rd_done  & is_owner;
  end

`ifdef RO_CACHE_RD_ARB_BEAT_CHECK_EN
  logic [LEN_WIDTH-1:0] beat_cnt_reg;
  logic                 err_beat_reg;
  logic                 beat_acc;

  assign beat_acc = rd_valid & rd_ready;

  // Done must land exactly on the latched length, counting a beat accepted in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_reg <= '0;
      err_beat_reg <= 1'b0;
    end else begin
      if (in_req && rd_gnt) beat_cnt_reg <= '0;
      else if (beat_acc)    beat_cnt_reg <= beat_cnt_reg + 1'b1;
      if (in_xfer && rd_done && ((beat_cnt_reg + LEN_WIDTH'(beat_acc)) != len_reg))
        err_beat_reg <= 1'b1;
      if (beat_acc && (beat_cnt_reg >= len_reg))
        err_beat_reg <= 1'b1;
    end
  end

  assign err_beat = err_beat_reg;
`endif

endmodule

// File: tb/tb_ro_cache_mem_rd_arb.sv
// Self-checking bench for ro_cache_mem_rd_arb: directed scenarios plus randomized bursts
// checked against a round-robin reference model.
module tb_ro_cache_mem_rd_arb;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     up_rd_req;
  logic [N-1:0]     up_rd_gnt;
  logic [16*N-1:0]  up_rd_len;
  logic [AW*N-1:0]  up_rd_addr;
  logic [DW-1:0]    up_rd_data;
  logic [N-1:0]     up_rd_valid;
  logic [N-1:0]     up_rd_ready;
  logic [N-1:0]     up_rd_done;
  logic             rd_req;
  logic             rd_gnt;
  logic [15:0]      rd_len;
  logic [AW-1:0]    rd_addr;
  logic [DW-1:0]    rd_data;
  logic             rd_valid;
  logic             rd_ready;
  logic             rd_done;
  logic             busy;
  logic [IDW-1:0]   owner;
`ifdef RO_CACHE_RD_ARB_BEAT_CHECK_EN
  logic             err_beat;
`endif

  ro_cache_mem_rd_arb #(
    .CACHE_NUM  (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .ID_WIDTH   (IDW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .up_rd_req   (up_rd_req),
    .up_rd_gnt   (up_rd_gnt),
    .up_rd_len   (up_rd_len),
    .up_rd_addr  (up_rd_addr),
    .up_rd_data  (up_rd_data),
    .up_rd_valid (up_rd_valid),
    .up_rd_ready (up_rd_ready),
    .up_rd_done  (up_rd_done),
    .rd_req      (rd_req),
    .rd_gnt      (rd_gnt),
    .rd_len      (rd_len),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_done     (rd_done),
    .busy        (busy),
    .owner       (owner)
`ifdef RO_CACHE_RD_ARB_BEAT_CHECK_EN
    ,
    .err_beat    (err_beat)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run    = 0;
  int tests_failed = 0;

  // Observations gathered by mem_serve for the calling test to judge.
  logic [N-1:0]   obs_gnt, obs_done;
  logic [15:0]    obs_len;
  logic [AW-1:0]  obs_addr;
  logic [IDW-1:0] obs_owner;
  int             obs_req_cyc, obs_done_cyc, obs_mem_beats, mirror_err;
  int             obs_beats [N];
  bit             obs_timeout;
  logic           obs_busy_after, obs_req_after;

  int model_ptr;

  function automatic int model_pick(input logic [N-1:0] req, input int ptr);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (ptr + k) % N;
      if (req[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; up_rd_req = '0; up_rd_ready = '0;
    rd_gnt = 1'b0; rd_valid = 1'b0; rd_done = 1'b0; rd_data = '0;
    tick(); tick();
    rst = 1'b0;
    model_ptr = 0;
  endtask

  // Plays the memory side for one burst and records what the arbiter did.
  task automatic mem_serve(input int exp_owner, input int gnt_delay, input int nbeats,
                           input bit toggle, input int abort_at);
    int guard, offered;
    bit r, phase, done_driven;
    logic [N-1:0] rdy, own_bit;
    own_bit = 4'b0001 << exp_owner;
    obs_gnt = '0; obs_done = '0; obs_timeout = 0; mirror_err = 0; obs_mem_beats = 0;
    obs_req_cyc = -1; obs_done_cyc = -1;
    for (int i = 0; i < N; i++) obs_beats[i] = 0;
    rd_gnt = 1'b0; rd_done = 1'b0; rd_valid = 1'b1; up_rd_ready = '1; rd_data = $urandom;
    #1;
    guard = 0;
    while (rd_req !== 1'b1) begin
      if (rd_ready !== 1'b0 || up_rd_valid !== '0 || up_rd_gnt !== '0) mirror_err++;
      if (guard == 40) begin obs_timeout = 1; return; end
      tick(); #1; guard++;
    end
    obs_req_cyc = cyc;
    if (rd_ready !== 1'b0 || up_rd_valid !== '0 || up_rd_gnt !== '0) mirror_err++;
    for (int d = 1; d < gnt_delay; d++) begin
      tick(); #1;
      if (rd_req !== 1'b1 || rd_ready !== 1'b0 || up_rd_valid !== '0 || up_rd_gnt !== '0) mirror_err++;
    end
    tick(); rd_gnt = 1'b1; rd_valid = 1'b0; #1;
    obs_gnt = up_rd_gnt; obs_len = rd_len; obs_addr = rd_addr; obs_owner = owner;
    offered = 0; done_driven = 0; phase = 1; guard = 0;
    while (!done_driven) begin
      tick();
      rd_gnt = 1'b0;
      r = toggle ? phase : 1'b1;
      phase = ~phase;
      rdy = 4'($urandom);
      rdy[exp_owner] = r;
      up_rd_ready = rdy;
      rd_valid = 1'b1;
      rd_data = $urandom;
      rd_done = r && (offered == nbeats - 1);
      #1;
      if (rd_req !== 1'b0 || rd_ready !== r || up_rd_valid !== own_bit ||
          up_rd_data !== rd_data || up_rd_gnt !== '0) mirror_err++;
      if (up_rd_done !== (rd_done ? own_bit : 4'b0000)) mirror_err++;
      for (int i = 0; i < N; i++) if (up_rd_valid[i] && up_rd_ready[i]) obs_beats[i]++;
      if (rd_valid && rd_ready) obs_mem_beats++;
      if (r) offered++;
      if (rd_done) begin done_driven = 1; obs_done = up_rd_done; obs_done_cyc = cyc; end
      if (abort_at >= 0 && offered == abort_at) return;
      guard++;
      if (guard > 100) begin obs_timeout = 1; break; end
    end
    tick();
    rd_valid = 1'b0; rd_done = 1'b0; up_rd_ready = '0;
    #1;
    obs_busy_after = busy; obs_req_after = rd_req;
  endtask

  task automatic test_reset();
    do_reset();
    rd_gnt = 1'b1; rd_valid = 1'b1; up_rd_ready = '1; rd_done = 1'b1;
    #1;
    tests_run++;
    if ({busy, rd_req, rd_ready, owner} !== '0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: busy/req/ready/owner=%b required 0", {busy, rd_req, rd_ready, owner});
    end
    tests_run++;
    if ({up_rd_gnt, up_rd_valid, up_rd_done} !== '0) begin
      tests_failed++;
      $display("FAIL reset_up: gnt/valid/done=%h required 0", {up_rd_gnt, up_rd_valid, up_rd_done});
    end
    tests_run++;
    if ({rd_len, rd_addr} !== '0) begin
      tests_failed++;
      $display("FAIL reset_len_addr: len=%h addr=%h required 0", rd_len, rd_addr);
    end
    rd_gnt = 1'b0; rd_valid = 1'b0; up_rd_ready = '0; rd_done = 1'b0;
  endtask

  task automatic test_single();
    int req_cyc;
    do_reset();
    tick();
    up_rd_len[2*16 +: 16] = 16'd4;
    up_rd_addr[2*AW +: AW] = 32'h100;
    up_rd_req = 4'b0100;
    req_cyc = cyc;
    mem_serve(2, 3, 4, 1'b0, -1);
    up_rd_req = '0;
    tests_run++;
    if (obs_timeout || obs_req_cyc !== req_cyc + 1) begin
      tests_failed++;
      $display("FAIL single_req_latency: rd_req at cycle %0d required %0d (timeout=%0d)", obs_req_cyc, req_cyc + 1, obs_timeout);
    end
    tests_run++;
    if (obs_gnt !== 4'b0100 || obs_owner !== 2'd2) begin
      tests_failed++;
      $display("FAIL single_gnt: gnt=%b owner=%0d required 0100/2", obs_gnt, obs_owner);
    end
    tests_run++;
    if (obs_len !== 16'd4 || obs_addr !== 32'h100) begin
      tests_failed++;
      $display("FAIL single_len_addr: len=%0d addr=%h required 4/100", obs_len, obs_addr);
    end
    tests_run++;
    if (obs_beats[2] != 4 || obs_beats[0] + obs_beats[1] + obs_beats[3] != 0 || obs_mem_beats != 4 || mirror_err != 0) begin
      tests_failed++;
      $display("FAIL single_beats: cache2=%0d others=%0d mem=%0d proto_errs=%0d required 4/0/4/0",
               obs_beats[2], obs_beats[0] + obs_beats[1] + obs_beats[3], obs_mem_beats, mirror_err);
    end
    tests_run++;
    if (obs_done !== 4'b0100 || obs_busy_after !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_done: done=%b busy_after=%b required 0100/0", obs_done, obs_busy_after);
    end
  endtask

  task automatic test_all_four();
    int exp, prev_done;
    do_reset();
    tick();
    for (int i = 0; i < N; i++) begin
      up_rd_len[i*16 +: 16] = 16'd2;
      up_rd_addr[i*AW +: AW] = 32'h40 * i;
    end
    up_rd_req = 4'b1111;
    prev_done = 0;
    for (int b = 0; b < N; b++) begin
      exp = model_pick(up_rd_req, model_ptr);
      mem_serve(exp, 1, 2, 1'b0, -1);
      tests_run++;
      if (obs_timeout || obs_gnt !== (4'b0001 << b) || obs_addr !== 32'h40 * b) begin
        tests_failed++;
        $display("FAIL all4_order[%0d]: gnt=%b addr=%h required %b/%h", b, obs_gnt, obs_addr, 4'b0001 << b, 32'h40 * b);
      end
      if (b > 0) begin
        tests_run++;
        if (obs_req_cyc - prev_done != 2) begin
          tests_failed++;
          $display("FAIL all4_bubble[%0d]: req-done gap=%0d required 2", b, obs_req_cyc - prev_done);
        end
      end
      tests_run++;
      if (obs_beats[exp] != 2 || mirror_err != 0 || obs_done !== (4'b0001 << exp)) begin
        tests_failed++;
        $display("FAIL all4_xfer[%0d]: beats=%0d proto_errs=%0d done=%b required 2/0/%b", b, obs_beats[exp], mirror_err, obs_done, 4'b0001 << exp);
      end
      prev_done = obs_done_cyc;
      up_rd_req[exp] = 1'b0;
      model_ptr = (exp + 1) % N;
    end
    // Pointer back at 0: caches 1 and 3 both waiting must resolve to 1.
    up_rd_len[1*16 +: 16] = 16'd1;
    up_rd_len[3*16 +: 16] = 16'd1;
    up_rd_req = 4'b1010;
    exp = model_pick(up_rd_req, model_ptr);
    mem_serve(exp, 1, 1, 1'b0, -1);
    tests_run++;
    if (obs_gnt !== 4'b0010) begin
      tests_failed++;
      $display("FAIL all4_ptr_wrap: gnt=%b required 0010", obs_gnt);
    end
    up_rd_req = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    tick();
    up_rd_len[1*16 +: 16] = 16'd8;
    up_rd_addr[1*AW +: AW] = 32'hABC0;
    up_rd_req = 4'b0010;
    mem_serve(1, 2, 8, 1'b1, -1);
    up_rd_req = '0;
    tests_run++;
    if (obs_timeout || mirror_err != 0) begin
      tests_failed++;
      $display("FAIL bp_mirror: proto_errs=%0d timeout=%0d required 0/0", mirror_err, obs_timeout);
    end
    tests_run++;
    if (obs_beats[1] != 8 || obs_mem_beats != 8 || obs_beats[0] + obs_beats[2] + obs_beats[3] != 0) begin
      tests_failed++;
      $display("FAIL bp_beats: cache1=%0d mem=%0d others=%0d required 8/8/0",
               obs_beats[1], obs_mem_beats, obs_beats[0] + obs_beats[2] + obs_beats[3]);
    end
  endtask

  task automatic test_fairness();
    int exp;
    bit got3;
    do_reset();
    tick();
    up_rd_len[0*16 +: 16] = 16'd2;
    up_rd_len[3*16 +: 16] = 16'd2;
    up_rd_req = 4'b1001;
    got3 = 0;
    for (int b = 0; b < 2; b++) begin
      exp = model_pick(up_rd_req, model_ptr);
      mem_serve(exp, 1, 2, 1'b0, -1);
      tests_run++;
      if (obs_gnt !== (4'b0001 << exp)) begin
        tests_failed++;
        $display("FAIL fair_gnt[%0d]: gnt=%b required %b", b, obs_gnt, 4'b0001 << exp);
      end
      if (obs_gnt[3]) got3 = 1;
      up_rd_req[exp] = 1'b0;
      if (exp == 0) up_rd_req[0] = 1'b1;
      model_ptr = (exp + 1) % N;
    end
    tests_run++;
    if (!got3) begin
      tests_failed++;
      $display("FAIL fair_starve: cache3 granted=%0d within 2 bursts required 1", got3);
    end
  endtask

  task automatic test_reset_mid_xfer();
    int exp;
    do_reset();
    tick();
    up_rd_len[1*16 +: 16] = 16'd2;
    up_rd_req = 4'b0010;
    mem_serve(1, 1, 2, 1'b0, -1);
    up_rd_len[2*16 +: 16] = 16'd4;
    up_rd_addr[2*AW +: AW] = 32'h2000;
    up_rd_req = 4'b0100;
    mem_serve(2, 1, 4, 1'b0, 2);
    tick();
    rst = 1'b1; up_rd_req = '0; rd_valid = 1'b1; rd_gnt = 1'b1; up_rd_ready = '1; rd_done = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    tests_run++;
    if ({busy, rd_req, rd_ready, up_rd_gnt, up_rd_valid, up_rd_done, owner, rd_len, rd_addr} !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: busy=%b req=%b ready=%b gnt=%b valid=%b done=%b owner=%0d len=%0d addr=%h required all 0",
               busy, rd_req, rd_ready, up_rd_gnt, up_rd_valid, up_rd_done, owner, rd_len, rd_addr);
    end
    rd_gnt = 1'b0; rd_valid = 1'b0;
    up_rd_len[1*16 +: 16] = 16'd1;
    up_rd_len[2*16 +: 16] = 16'd1;
    up_rd_req = 4'b0110;
    model_ptr = 0;
    exp = model_pick(up_rd_req, model_ptr);
    mem_serve(exp, 1, 1, 1'b0, -1);
    tests_run++;
    if (obs_timeout || obs_gnt !== 4'b0010) begin
      tests_failed++;
      $display("FAIL rst_mid_ptr: gnt=%b required 0010", obs_gnt);
    end
    up_rd_req = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] pending, fresh;
    int lens [N];
    logic [AW-1:0] addrs [N];
    int waits [N];
    int exp, prev_done;
    do_reset();
    tick();
    pending = '0;
    prev_done = -1;
    for (int i = 0; i < N; i++) begin lens[i] = 1; addrs[i] = '0; waits[i] = 0; end
    for (int it = 0; it < 30; it++) begin
      fresh = 4'($urandom_range(0, 15)) & ~pending;
      if ((pending | fresh) == '0) fresh[$urandom_range(0, N - 1)] = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (fresh[i]) begin
          lens[i] = $urandom_range(1, 5);
          addrs[i] = $urandom;
          up_rd_len[i*16 +: 16] = 16'(lens[i]);
          up_rd_addr[i*AW +: AW] = addrs[i];
          waits[i] = 0;
        end
      end
      pending = pending | fresh;
      up_rd_req = pending;
      exp = model_pick(pending, model_ptr);
      mem_serve(exp, $urandom_range(1, 3), lens[exp], 1'($urandom_range(0, 1)), -1);
      tests_run++;
      if (obs_timeout || obs_gnt !== (4'b0001 << exp) || obs_len !== 16'(lens[exp]) || obs_addr !== addrs[exp]) begin
        tests_failed++;
        $display("FAIL rand_gnt[%0d]: gnt=%b len=%0d addr=%h required %b/%0d/%h",
                 it, obs_gnt, obs_len, obs_addr, 4'b0001 << exp, lens[exp], addrs[exp]);
      end
      tests_run++;
      if (obs_beats[exp] != lens[exp] || obs_mem_beats != lens[exp] || mirror_err != 0 || obs_done !== (4'b0001 << exp)) begin
        tests_failed++;
        $display("FAIL rand_xfer[%0d]: beats=%0d mem=%0d proto_errs=%0d done=%b required %0d/%0d/0/%b",
                 it, obs_beats[exp], obs_mem_beats, mirror_err, obs_done, lens[exp], lens[exp], 4'b0001 << exp);
      end
      if (prev_done >= 0) begin
        tests_run++;
        if (obs_req_cyc - prev_done != 2) begin
          tests_failed++;
          $display("FAIL rand_bubble[%0d]: req-done gap=%0d required 2", it, obs_req_cyc - prev_done);
        end
      end
      prev_done = obs_done_cyc;
      pending[exp] = 1'b0;
      up_rd_req = pending;
      for (int i = 0; i < N; i++) if (pending[i]) waits[i]++;
      tests_run++;
      if (waits[0] > N - 1 || waits[1] > N - 1 || waits[2] > N - 1 || waits[3] > N - 1) begin
        tests_failed++;
        $display("FAIL rand_starve[%0d]: waits=%0d,%0d,%0d,%0d required <=%0d", it, waits[0], waits[1], waits[2], waits[3], N - 1);
      end
      model_ptr = (exp + 1) % N;
    end
    up_rd_req = '0;
  endtask

`ifdef RO_CACHE_RD_ARB_BEAT_CHECK_EN
  task automatic test_beat_check();
    do_reset();
    #1;
    tests_run++;
    if (err_beat !== 1'b0) begin
      tests_failed++;
      $display("FAIL beat_reset: err_beat=%b required 0", err_beat);
    end
    tick();
    up_rd_len[0*16 +: 16] = 16'd4;
    up_rd_req = 4'b0001;
    mem_serve(0, 1, 3, 1'b0, -1);
    up_rd_req = '0;
    tests_run++;
    if (err_beat !== 1'b1) begin
      tests_failed++;
      $display("FAIL beat_short: err_beat=%b required 1", err_beat);
    end
    tick(); tick(); tick();
    tests_run++;
    if (err_beat !== 1'b1) begin
      tests_failed++;
      $display("FAIL beat_sticky: err_beat=%b required 1", err_beat);
    end
    do_reset();
    tick();
    up_rd_len[0*16 +: 16] = 16'd4;
    up_rd_req = 4'b0001;
    mem_serve(0, 2, 4, 1'b1, -1);
    up_rd_req = '0;
    tests_run++;
    if (err_beat !== 1'b0) begin
      tests_failed++;
      $display("FAIL beat_exact: err_beat=%b required 0", err_beat);
    end
    up_rd_len[0*16 +: 16] = 16'd2;
    up_rd_req = 4'b0001;
    mem_serve(0, 1, 3, 1'b0, -1);
    up_rd_req = '0;
    tests_run++;
    if (err_beat !== 1'b1) begin
      tests_failed++;
      $display("FAIL beat_over: err_beat=%b required 1", err_beat);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    up_rd_req = '0; up_rd_len = '0; up_rd_addr = '0; up_rd_ready = '0;
    rd_gnt = 1'b0; rd_data = '0; rd_valid = 1'b0; rd_done = 1'b0;
    model_ptr = 0;
    test_reset();
    test_single();
    test_all_four();
    test_backpressure();
    test_fairness();
    test_reset_mid_xfer();
    test_random();
`ifdef RO_CACHE_RD_ARB_BEAT_CHECK_EN
    test_beat_check();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

endmodule
